regfile_mp_sb: RTL and testbench
================================

# regfile_mp_sb

Parametrised multi-port general register file for the pipelined MIPS core, located in the decode stage. It provides NUM_RD combinational read ports, two write-back ports for dual retirement, an optional write-to-read bypass, and a per-register pending-write scoreboard. The scoreboard lets the hazard unit stall on registers that have an in-flight producer. Register 0 reads as zero, is never written and is never pending.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = plain array read
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data per port (combinational)
- rd_ready  out  NUM_RD  1 = addressed register has no pending write (combinational)
- wr0_en, wr0_addr, wr0_data  in  1, ADDR_W, DATA_W  write port 0 (older retiring instruction)
- wr1_en, wr1_addr, wr1_data  in  1, ADDR_W, DATA_W  write port 1 (younger instruction)
- mark_en, mark_addr  in  1, ADDR_W  sets the pending bit of mark_addr (issue of a producer)
- flush  in  1  clears every pending bit (pipeline flush)
- pending_cnt  out  ADDR_W+1  registered count of pending registers

## Operation
- Storage: 2**ADDR_W x DATA_W array plus a 2**ADDR_W pending vector. Entry 0 of both is constant 0.
- Write: on the clock edge, each enabled port with a nonzero address writes its data. If both ports target the same nonzero address, port 1's data is stored. Address 0 writes are ignored.
- Read, BYPASS=0: rd_data[k] = array[rd_addr[k]].
- Read, BYPASS=1: if wr1_en and wr1_addr == rd_addr[k] != 0, rd_data[k] = wr1_data. Otherwise, if wr0_en and wr0_addr == rd_addr[k] != 0, rd_data[k] = wr0_data. Otherwise the array value is returned.
- Address 0 always reads 0, and rd_ready is 1 for address 0.
- Pending next-state, evaluated per register r != 0, in priority order:
  - flush: 0
  - mark_en and mark_addr == r: 1 (a new producer overrides a same-cycle clear)
  - write enabled to r on either port: 0
  - otherwise: hold
- mark_addr == 0 has no effect.
- rd_ready[k] = !pending[rd_addr[k]]. When BYPASS=1, rd_ready[k] is also 1 if a same-cycle write targets rd_addr[k].
- pending_cnt is registered and equals the popcount of the pending vector after the edge, so it always matches the stored vector. The range is 0..2**ADDR_W-1, so the counter cannot overflow.

## Timing
- Reset: all registers become 0, all pending bits 0, pending_cnt 0. Consequently every rd_data is 0 and every rd_ready is 1 in the cycle after reset. Reset overrides all same-cycle writes, marks and flushes.
- Write latency: the array is updated at the edge. Reads see the new value the following cycle with BYPASS=0, and in the same cycle with BYPASS=1.
- Mark latency: the pending bit, and rd_ready=0, take effect in the cycle after mark_en.
- Clear latency: with BYPASS=1, rd_ready rises in the writing cycle; with BYPASS=0 it rises the next cycle.
- No handshakes. Every input is sampled every cycle, and there are no stall or back-pressure paths.

## Test plan
- Reset then read all 32 addresses on every port -> rd_data=0, rd_ready=1, pending_cnt=0.
- wr0 x5=0x1234 and wr1 x5=0xABCD in the same cycle, BYPASS=1, rd_addr[0]=5 -> rd_data=0xABCD that cycle and the next. Same test with BYPASS=0 -> old value that cycle, 0xABCD the next.
- wr0 to x0 with 0xFFFFFFFF, plus mark x0 -> rd_data(0)=0, rd_ready=1, pending_cnt unchanged.
- mark x3, x7, then x9 on consecutive cycles -> pending_cnt goes 1, 2, 3 and rd_ready(3)=0. Then wr0 x7 -> rd_ready(7)=1 in the same cycle (BYPASS=1) and pending_cnt=2 next.
- mark x4 and wr1 x4 in the same cycle -> x4 data updated, pending(4)=1, pending_cnt increments.
- Several pending registers, then flush together with mark x6 -> all pending 0, pending_cnt=0. Then assert reset mid-stream -> all state back to reset values.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: decode-stage general register file for the pipelined MIPS core.
// It has NUM_RD combinational read ports and two write-back ports for dual retirement.
// It can optionally forward same-cycle write data to the read ports.
// A per-register pending-write scoreboard lets the hazard unit stall on in-flight producers.
// Register 0 reads as zero, is never written and is never pending.
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       mark_en,
  input  logic [ADDR_W-1:0]          mark_addr,
  input  logic                       flush,
  output logic [ADDR_W:0]            pending_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic [ADDR_W:0]   cnt_next;
  logic [ADDR_W:0]   cnt_q;

  // Register array update.
  // Port 1 is the younger instruction, so it wins a same-address collision.
  // Entry 0 is only ever cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (wr1_en && (wr1_addr == ADDR_W'(r))) begin
          mem[r] <= wr1_data;
        end else if (wr0_en && (wr0_addr == ADDR_W'(r))) begin
          mem[r] <= wr0_data;
        end
      end
    end
  end

  // Scoreboard next state.
  // Flush beats everything.
  // A new producer beats a same-cycle retirement to the same register.
  always_comb begin
    pending_next = pending;
    for (int r = 1; r < DEPTH; r++) begin
      if (flush) begin
        pending_next[r] = 1'b0;
      end else if (mark_en && (mark_addr == ADDR_W'(r))) begin
        pending_next[r] = 1'b1;
      end else if ((wr0_en && (wr0_addr == ADDR_W'(r))) ||
                   (wr1_en && (wr1_addr == ADDR_W'(r)))) begin
        pending_next[r] = 1'b0;
      end
    end
    pending_next[0] = 1'b0;
  end

  // Popcount of the next pending vector.
  // The registered count therefore always matches the stored bits.
  always_comb begin
    cnt_next = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_next = cnt_next + {{ADDR_W{1'b0}}, pending_next[r]};
    end
  end

  // Scoreboard vector and its count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      cnt_q   <= '0;
    end else begin
      pending <= pending_next;
      cnt_q   <= cnt_next;
    end
  end

  assign pending_cnt = cnt_q;

  // Read ports.
  // With bypass enabled, write port 1 is checked before port 0, matching the storage priority.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              nonzero;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] arr_val;

    assign ra      = rd_addr[k*ADDR_W +: ADDR_W];
    assign nonzero = (ra != '0);
    assign hit1    = BYP && nonzero && wr1_en && (wr1_addr == ra);
    assign hit0    = BYP && nonzero && wr0_en && (wr0_addr == ra);
    assign arr_val = nonzero ? mem[ra] : '0;

    assign rd_data[k*DATA_W +: DATA_W] = hit1 ? wr1_data :
                                         hit0 ? wr0_data : arr_val;
    assign rd_ready[k] = !pending[ra] || hit0 || hit1;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed test of regfile_mp_sb.
// One bypassing instance and one plain instance share the same stimulus.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic        wr0_en = 1'b0, wr1_en = 1'b0, mark_en = 1'b0, flush = 1'b0;
  logic [4:0]  wr0_addr = '0, wr1_addr = '0, mark_addr = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;

  logic [63:0] rd_data_bp, rd_data_nb;
  logic [1:0]  rd_ready_bp, rd_ready_nb;
  logic [5:0]  cnt_bp, cnt_nb;

  int checkCount = 0;
  int failCount  = 0;

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_bp),
    .rd_ready(rd_ready_bp), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .mark_en(mark_en), .mark_addr(mark_addr),
    .flush(flush), .pending_cnt(cnt_bp)
  );

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_ready(rd_ready_nb), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .mark_en(mark_en), .mark_addr(mark_addr),
    .flush(flush), .pending_cnt(cnt_nb)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the falling edge.
  // Settle briefly so combinational outputs can be sampled before the next rising edge.
  task automatic applyStimulus(
    input logic rs,
    input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
    input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
    input logic me, input logic [4:0] ma, input logic fl,
    input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    reset = rs;
    wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
    wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
    mark_en = me; mark_addr = ma; flush = fl;
    rd_addr = {ra1, ra0};
    #2;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, ra0, ra1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset, then sweep every address on both ports of both instances.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      idle(5'(a), 5'(31 - a));
      checkOutput($sformatf("rst_data_bp_a%0d", a), rd_data_bp[31:0], 32'd0);
      checkOutput($sformatf("rst_data_nb_b%0d", a), rd_data_nb[63:32], 32'd0);
      checkOutput($sformatf("rst_ready_bp_a%0d", a), {30'd0, rd_ready_bp}, 32'd3);
      checkOutput($sformatf("rst_ready_nb_a%0d", a), {30'd0, rd_ready_nb}, 32'd3);
    end
    checkOutput("rst_cnt_bp", {26'd0, cnt_bp}, 32'd0);
    checkOutput("rst_cnt_nb", {26'd0, cnt_nb}, 32'd0);

    // Dual write to x5: port 1 must win, bypassed immediately or visible next cycle.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 32'hABCD, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
    checkOutput("x5_same_bp", rd_data_bp[31:0], 32'hABCD);
    checkOutput("x5_same_nb", rd_data_nb[31:0], 32'h0);
    idle(5'd5, 5'd0);
    checkOutput("x5_next_bp", rd_data_bp[31:0], 32'hABCD);
    checkOutput("x5_next_nb", rd_data_nb[31:0], 32'hABCD);

    // Write and mark of x0 must have no effect.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    checkOutput("x0_same_bp", rd_data_bp[31:0], 32'h0);
    checkOutput("x0_ready_bp", {31'd0, rd_ready_bp[0]}, 32'd1);
    idle(5'd0, 5'd5);
    checkOutput("x0_next_bp", rd_data_bp[31:0], 32'h0);
    checkOutput("x0_next_nb", rd_data_nb[31:0], 32'h0);
    checkOutput("x0_ready_nb", {31'd0, rd_ready_nb[0]}, 32'd1);
    checkOutput("x0_cnt_bp", {26'd0, cnt_bp}, 32'd0);

    // Mark x3, x7 and x9 on consecutive cycles.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
    checkOutput("m3_ready_same_bp", {31'd0, rd_ready_bp[0]}, 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd3, 5'd0);
    checkOutput("m3_cnt_bp", {26'd0, cnt_bp}, 32'd1);
    checkOutput("m3_ready_bp", {31'd0, rd_ready_bp[0]}, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd3, 5'd7);
    checkOutput("m7_cnt_bp", {26'd0, cnt_bp}, 32'd2);
    checkOutput("m7_ready_nb", {30'd0, rd_ready_nb}, 32'd0);

    // Retire x7 through write port 0.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd9);
    checkOutput("m9_cnt_bp", {26'd0, cnt_bp}, 32'd3);
    checkOutput("m9_cnt_nb", {26'd0, cnt_nb}, 32'd3);
    checkOutput("w7_ready_same_bp", {30'd0, rd_ready_bp}, 32'd1);
    checkOutput("w7_ready_same_nb", {30'd0, rd_ready_nb}, 32'd0);
    checkOutput("w7_data_same_bp", rd_data_bp[31:0], 32'h77);
    idle(5'd7, 5'd3);
    checkOutput("w7_cnt_bp", {26'd0, cnt_bp}, 32'd2);
    checkOutput("w7_ready_next_nb", {30'd0, rd_ready_nb}, 32'd1);
    checkOutput("w7_data_next_nb", rd_data_nb[31:0], 32'h77);

    // Mark and write x4 in the same cycle: the data lands and the mark wins.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0);
    checkOutput("mw4_data_same_bp", rd_data_bp[31:0], 32'h44);
    checkOutput("mw4_ready_same_bp", {31'd0, rd_ready_bp[0]}, 32'd1);
    idle(5'd4, 5'd9);
    checkOutput("mw4_cnt_bp", {26'd0, cnt_bp}, 32'd3);
    checkOutput("mw4_cnt_nb", {26'd0, cnt_nb}, 32'd3);
    checkOutput("mw4_ready_bp", {30'd0, rd_ready_bp}, 32'd0);
    checkOutput("mw4_data_nb", rd_data_nb[31:0], 32'h44);

    // Flush together with a mark of x6 clears everything.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b1, 5'd6, 5'd3);
    idle(5'd6, 5'd4);
    checkOutput("fl_cnt_bp", {26'd0, cnt_bp}, 32'd0);
    checkOutput("fl_cnt_nb", {26'd0, cnt_nb}, 32'd0);
    checkOutput("fl_ready_bp", {30'd0, rd_ready_bp}, 32'd3);
    checkOutput("fl_ready_nb", {30'd0, rd_ready_nb}, 32'd3);

    // Build some state, then reset alongside a write and a mark.
    applyStimulus(1'b0, 1'b1, 5'd12, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 5'd12, 5'd10);
    idle(5'd12, 5'd10);
    checkOutput("pre_rst_cnt_bp", {26'd0, cnt_bp}, 32'd1);
    checkOutput("pre_rst_data_nb", rd_data_nb[31:0], 32'h99);
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0, 5'd5, 5'd11);
    idle(5'd5, 5'd12);
    checkOutput("post_rst_x5_bp", rd_data_bp[31:0], 32'h0);
    checkOutput("post_rst_x12_bp", rd_data_bp[63:32], 32'h0);
    checkOutput("post_rst_x12_nb", rd_data_nb[63:32], 32'h0);
    checkOutput("post_rst_cnt_bp", {26'd0, cnt_bp}, 32'd0);
    checkOutput("post_rst_cnt_nb", {26'd0, cnt_nb}, 32'd0);
    idle(5'd11, 5'd10);
    checkOutput("post_rst_ready_bp", {30'd0, rd_ready_bp}, 32'd3);
    checkOutput("post_rst_ready_nb", {30'd0, rd_ready_nb}, 32'd3);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
